// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, FSM state
// encodings, datapath mux encodings and the packed control word.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // FSM state encodings; 12-15 are unused and decode to all-zero outputs
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } ctrl_state_e;

  // ALU B-operand select
  localparam logic [1:0] SrcbB     = 2'b00;
  localparam logic [1:0] SrcbFour  = 2'b01;
  localparam logic [1:0] SrcbImm   = 2'b10;
  localparam logic [1:0] SrcbImmSh = 2'b11;

  // ALU operation class
  localparam logic [1:0] AluopAdd   = 2'b00;
  localparam logic [1:0] AluopSub   = 2'b01;
  localparam logic [1:0] AluopFunct = 2'b10;

  // Next-PC select
  localparam logic [1:0] PcsrcAlu    = 2'b00;
  localparam logic [1:0] PcsrcAluOut = 2'b01;
  localparam logic [1:0] PcsrcJump   = 2'b10;

  // Control word produced by the output decoder
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_word_t;

  // True for every opcode the FSM knows how to sequence
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
           (op == OpBeq) || (op == OpAddi) || (op == OpJ);
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational output decoder: (state, mem_ready) -> datapath control word.
module mips_mc_outdec
  import mips_ctrl_pkg::*;
(
  input  ctrl_state_e i_state,
  input  logic        i_mem_ready,
  output ctrl_word_t  o_ctrl
);

  // Decode per-state strobes; anything not named stays 0
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      StFetch: begin
        o_ctrl.iord    = 1'b0;
        o_ctrl.alusrca = 1'b0;
        o_ctrl.alusrcb = SrcbFour;
        o_ctrl.aluop   = AluopAdd;
        o_ctrl.pcsrc   = PcsrcAlu;
        // Gate on ready so a stalled fetch never double-increments PC
        o_ctrl.irwrite = i_mem_ready;
        o_ctrl.pcwrite = i_mem_ready;
      end
      StDecode: begin
        o_ctrl.alusrca = 1'b0;
        o_ctrl.alusrcb = SrcbImmSh;
        o_ctrl.aluop   = AluopAdd;
      end
      StMemAdr: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SrcbImm;
        o_ctrl.aluop   = AluopAdd;
      end
      StMemRd: begin
        o_ctrl.iord = 1'b1;
      end
      StMemWb: begin
        o_ctrl.regdst   = 1'b0;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      StMemWr: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      StExec: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SrcbB;
        o_ctrl.aluop   = AluopFunct;
      end
      StAluWb: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.memtoreg = 1'b0;
        o_ctrl.regwrite = 1'b1;
      end
      StBranch: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SrcbB;
        o_ctrl.aluop   = AluopSub;
        o_ctrl.pcsrc   = PcsrcAluOut;
        o_ctrl.branch  = 1'b1;
      end
      StAddiEx: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SrcbImm;
        o_ctrl.aluop   = AluopAdd;
      end
      StAddiWb: begin
        o_ctrl.regdst   = 1'b0;
        o_ctrl.memtoreg = 1'b0;
        o_ctrl.regwrite = 1'b1;
      end
      StJump: begin
        o_ctrl.pcsrc   = PcsrcJump;
        o_ctrl.pcwrite = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, pcen and
// illegal-opcode detection. Outputs are combinational from state and inputs.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state_o
);

  ctrl_state_e r_state;
  ctrl_state_e w_state_next;
  ctrl_word_t  w_ctrl;

  // State register; reset drops straight back to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; opcode only matters in DECODE and MEMADR
  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch:  w_state_next = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: w_state_next = StMemAdr;
          OpRtype:    w_state_next = StExec;
          OpBeq:      w_state_next = StBranch;
          OpAddi:     w_state_next = StAddiEx;
          OpJ:        w_state_next = StJump;
          default:    w_state_next = StFetch;
        endcase
      end
      StMemAdr: begin
        if (opcode == OpLw) begin
          w_state_next = StMemRd;
        end else if (opcode == OpSw) begin
          w_state_next = StMemWr;
        end else begin
          w_state_next = StFetch;
        end
      end
      StMemRd:  w_state_next = mem_ready ? StMemWb : StMemRd;
      StMemWb:  w_state_next = StFetch;
      StMemWr:  w_state_next = mem_ready ? StFetch : StMemWr;
      StExec:   w_state_next = StAluWb;
      StAluWb:  w_state_next = StFetch;
      StBranch: w_state_next = StFetch;
      StAddiEx: w_state_next = StAddiWb;
      StAddiWb: w_state_next = StFetch;
      StJump:   w_state_next = StFetch;
      default:  w_state_next = StFetch;
    endcase
  end

  mips_mc_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign iord     = w_ctrl.iord;
  assign memwrite = w_ctrl.memwrite;
  assign irwrite  = w_ctrl.irwrite;
  assign regdst   = w_ctrl.regdst;
  assign memtoreg = w_ctrl.memtoreg;
  assign regwrite = w_ctrl.regwrite;
  assign alusrca  = w_ctrl.alusrca;
  assign alusrcb  = w_ctrl.alusrcb;
  assign aluop    = w_ctrl.aluop;
  assign pcsrc    = w_ctrl.pcsrc;
  assign pcen     = w_ctrl.pcwrite | (w_ctrl.branch & zero);
  assign illegal  = (r_state == StDecode) && !op_supported(opcode);
  assign state_o  = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through the
// FSM and checks state and the full control bundle in every cycle.
module tb_mips_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, illegal;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;

  mips_mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .pcsrc     (pcsrc),
    .pcen      (pcen),
    .illegal   (illegal),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [14:0] obs_cw = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                        alusrcb, aluop, pcsrc, pcen, illegal};

  function automatic logic [14:0] cw(input logic io, input logic mw, input logic irw,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] psrc,
                                     input logic pe, input logic ill);
    return {io, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pe, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge, check mid-cycle, then advance
  task automatic step(input string tag, input logic mr, input logic z, input logic [5:0] op,
                      input logic [3:0] exp_st, input logic [14:0] exp_cw);
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    @(negedge clk);
    chk({tag, ".state"}, {28'd0, state_o}, {28'd0, exp_st});
    chk({tag, ".ctrl"}, {17'd0, obs_cw}, {17'd0, exp_cw});
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] Rt = 6'b000000, Lw = 6'b100011, Sw = 6'b101011;
  localparam logic [5:0] Beq = 6'b000100, Addi = 6'b001000, Jmp = 6'b000010;
  localparam logic [5:0] Bad = 6'b111111;

  logic [14:0] c_fetch, c_fetch_st, c_dec, c_madr, c_mrd, c_mwb, c_mwr;
  logic [14:0] c_exec, c_awb, c_br1, c_br0, c_iwb, c_jmp, c_dec_ill;

  initial begin
    c_fetch    = cw(0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    c_fetch_st = cw(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    c_dec      = cw(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
    c_dec_ill  = cw(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1);
    c_madr     = cw(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    c_mrd      = cw(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    c_mwb      = cw(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    c_mwr      = cw(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    c_exec     = cw(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
    c_awb      = cw(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    c_br1      = cw(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
    c_br0      = cw(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0);
    c_iwb      = cw(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    c_jmp      = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);

    // Reset: FETCH, and fetch strobes follow mem_ready
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = Rt;
    #1;
    chk("rst.state", {28'd0, state_o}, 32'd0);
    chk("rst.ctrl_mr1", {17'd0, obs_cw}, {17'd0, c_fetch});
    mem_ready = 1'b0;
    #1;
    chk("rst.ctrl_mr0", {17'd0, obs_cw}, {17'd0, c_fetch_st});
    @(posedge clk); #1;
    chk("rst.hold", {28'd0, state_o}, 32'd0);
    reset = 1'b0;

    // lw, no stalls: 0,1,2,3,4
    step("lw.fetch", 1, 0, Lw, 4'd0, c_fetch);
    step("lw.dec",   1, 0, Lw, 4'd1, c_dec);
    step("lw.madr",  1, 0, Lw, 4'd2, c_madr);
    step("lw.mrd",   1, 0, Lw, 4'd3, c_mrd);
    step("lw.mwb",   1, 0, Lw, 4'd4, c_mwb);

    // sw with two MEMWR stall cycles
    step("sw.fetch", 1, 0, Sw, 4'd0, c_fetch);
    step("sw.dec",   1, 0, Sw, 4'd1, c_dec);
    step("sw.madr",  1, 0, Sw, 4'd2, c_madr);
    step("sw.mwr0",  0, 0, Sw, 4'd5, c_mwr);
    step("sw.mwr1",  0, 0, Sw, 4'd5, c_mwr);
    step("sw.mwr2",  1, 0, Sw, 4'd5, c_mwr);

    // FETCH stalls 3 cycles, then R-type; opcode change in EXEC is ignored
    step("rt.stall0", 0, 0, Rt, 4'd0, c_fetch_st);
    step("rt.stall1", 0, 0, Rt, 4'd0, c_fetch_st);
    step("rt.stall2", 0, 0, Rt, 4'd0, c_fetch_st);
    step("rt.fetch",  1, 0, Rt, 4'd0, c_fetch);
    step("rt.dec",    1, 0, Rt, 4'd1, c_dec);
    step("rt.exec",   1, 0, Jmp, 4'd6, c_exec);
    step("rt.awb",    1, 0, Jmp, 4'd7, c_awb);

    // lw with one MEMRD stall
    step("lws.fetch", 1, 0, Lw, 4'd0, c_fetch);
    step("lws.dec",   1, 0, Lw, 4'd1, c_dec);
    step("lws.madr",  1, 0, Lw, 4'd2, c_madr);
    step("lws.mrd0",  0, 0, Lw, 4'd3, c_mrd);
    step("lws.mrd1",  1, 0, Lw, 4'd3, c_mrd);
    step("lws.mwb",   1, 0, Lw, 4'd4, c_mwb);

    // beq taken then not taken
    step("beq1.fetch", 1, 0, Beq, 4'd0, c_fetch);
    step("beq1.dec",   1, 0, Beq, 4'd1, c_dec);
    step("beq1.br",    1, 1, Beq, 4'd8, c_br1);
    step("beq0.fetch", 1, 0, Beq, 4'd0, c_fetch);
    step("beq0.dec",   1, 0, Beq, 4'd1, c_dec);
    step("beq0.br",    1, 0, Beq, 4'd8, c_br0);

    // addi
    step("addi.fetch", 1, 0, Addi, 4'd0, c_fetch);
    step("addi.dec",   1, 0, Addi, 4'd1, c_dec);
    step("addi.ex",    1, 0, Addi, 4'd9, c_madr);
    step("addi.wb",    1, 0, Addi, 4'd10, c_iwb);

    // j
    step("j.fetch", 1, 0, Jmp, 4'd0, c_fetch);
    step("j.dec",   1, 0, Jmp, 4'd1, c_dec);
    step("j.jump",  1, 0, Jmp, 4'd11, c_jmp);

    // Unsupported opcode: illegal pulse in DECODE, then FETCH
    step("ill.fetch", 1, 0, Bad, 4'd0, c_fetch);
    step("ill.dec",   1, 0, Bad, 4'd1, c_dec_ill);
    step("ill.back",  0, 0, Bad, 4'd0, c_fetch_st);

    // Reset mid-MEMWR: memwrite and state drop without a clock edge
    step("rsw.fetch", 1, 0, Sw, 4'd0, c_fetch);
    step("rsw.dec",   1, 0, Sw, 4'd1, c_dec);
    step("rsw.madr",  1, 0, Sw, 4'd2, c_madr);
    mem_ready = 1'b0;
    #1;
    chk("rsw.inwr", {28'd0, state_o}, 32'd5);
    #1;
    reset = 1'b1;
    #1;
    chk("rsw.rst_state", {28'd0, state_o}, 32'd0);
    chk("rsw.rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("rsw.rst_regwrite", {31'd0, regwrite}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step("rsw.fetch2", 1, 0, Addi, 4'd0, c_fetch);
    step("rsw.dec2",   1, 0, Addi, 4'd1, c_dec);
    step("rsw.ex2",    1, 0, Addi, 4'd9, c_madr);
    step("rsw.wb2",    1, 0, Addi, 4'd10, c_iwb);
    step("rsw.end",    1, 0, Addi, 4'd0, c_fetch);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
